// File: rtl/deck_shuffler_pkg.sv
// Shared card types, deck constants and LFSR step function for the deck shuffler.
package deck_shuffler_pkg;

  localparam int          DECK_SIZE = 52;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [3:0] {
    TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE, TEN, JACK, QUEEN, KING, ACE
  } rank_t;

  typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, READY} deck_state_t;

  // Card sitting at position k of a fresh, unshuffled deck.
  function automatic card_t ident_card(input int k);
    card_t c;
    c.rank = rank_t'(4'(k % 13));
    c.suit = suit_t'(2'(k / 13));
    return c;
  endfunction

  // One Galois shift: output bit falls out of bit 0 and folds back into the taps.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads the seed on reset.
module lfsr16
  import deck_shuffler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Advance every cycle so the shuffle outcome depends on when it starts.
  always_ff @(posedge clk) begin
    if (reset) q <= seed;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/deck_shuffler.sv
// 52-card deck held in flops, shuffled in place (Fisher-Yates, one swap per
// cycle) and served one card per draw_card pulse.
// Build option: define DECK_BYPASS_SHUFFLE_EN to skip the shuffle and deal
// the deck in identity order (ready two cycles after start).
module deck_shuffler
  import deck_shuffler_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          DECK_SIZE = deck_shuffler_pkg::DECK_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_shuffle,
  input  logic       draw_card,
  output card_t      top_card,
  output logic       ready,
  output logic [5:0] cards_left,
  output logic       empty
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [5:0]  LAST     = 6'(DECK_SIZE - 1);
  localparam logic [5:0]  FULL     = 6'(DECK_SIZE);

  deck_state_t state;
  card_t       deck [DECK_SIZE];
  logic [5:0]  ptr;
  logic [15:0] rnd;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_EFF),
    .q     (rnd)
  );

`ifndef DECK_BYPASS_SHUFFLE_EN
  logic [5:0]  i;
  logic [5:0]  j;
  logic [13:0] prod;
  logic [15:0] unused_bits;

  // Scale the random byte into 0..i: (rnd[7:0] * (i+1)) >> 8 never exceeds i.
  assign prod        = {6'd0, rnd[7:0]} * {8'd0, i + 6'd1};
  assign j           = prod[13:8];
  assign unused_bits = {rnd[15:8], prod[7:0]};
`else
  logic [15:0] unused_bits;
  assign unused_bits = rnd;
`endif

  // Once ptr runs past the last card the read clamps to the bottom card.
  assign top_card = deck[(ptr > LAST) ? LAST : ptr];
  assign empty    = (cards_left == 6'd0);

  // Deck controller: restart beats draw, one swap per SHUFFLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 6'd0;
      cards_left <= 6'd0;
      ready      <= 1'b0;
`ifndef DECK_BYPASS_SHUFFLE_EN
      i          <= 6'd0;
`endif
      for (int k = 0; k < DECK_SIZE; k++) deck[k] <= ident_card(k);
    end else if (start_shuffle) begin
      // Any in-flight shuffle or partially dealt deck is abandoned.
      state      <= INIT;
      ready      <= 1'b0;
      cards_left <= 6'd0;
    end else begin
      unique case (state)
        IDLE: ;
        INIT: begin
          ptr <= 6'd0;
          for (int k = 0; k < DECK_SIZE; k++) deck[k] <= ident_card(k);
`ifdef DECK_BYPASS_SHUFFLE_EN
          state      <= READY;
          cards_left <= FULL;
          ready      <= 1'b1;
`else
          i     <= LAST;
          state <= SHUFFLE;
`endif
        end
        SHUFFLE: begin
`ifndef DECK_BYPASS_SHUFFLE_EN
          // j == i writes the same card back, so no special case is needed.
          deck[i] <= deck[j];
          deck[j] <= deck[i];
          if (i == 6'd1) begin
            state      <= READY;
            cards_left <= FULL;
            ready      <= 1'b1;
          end else begin
            i <= i - 6'd1;
          end
`else
          state <= IDLE;
`endif
        end
        READY: begin
          if (draw_card && (cards_left != 6'd0)) begin
            ptr        <= ptr + 6'd1;
            cards_left <= cards_left - 6'd1;
            ready      <= (cards_left != 6'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler (default build: full shuffle).
module tb_deck_shuffler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_shuffle = 1'b0;
  logic       draw_card = 1'b0;
  logic [5:0] top_card;
  logic       ready;
  logic [5:0] cards_left;
  logic       empty;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  exp_deck [52];

  deck_shuffler dut (
    .clk           (clk),
    .reset         (reset),
    .start_shuffle (start_shuffle),
    .draw_card     (draw_card),
    .top_card      (top_card),
    .ready         (ready),
    .cards_left    (cards_left),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    return r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
  endfunction

  // Reference LFSR running in lockstep with the clock.
  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Fisher-Yates from identity; r0 is the random word seen by the first swap.
  task automatic model_shuffle(input logic [15:0] r0);
    logic [15:0] r;
    logic [5:0]  t;
    int          j;
    r = r0;
    for (int k = 0; k < 52; k++) exp_deck[k] = {4'(k % 13), 2'(k / 13)};
    for (int i = 51; i >= 1; i--) begin
      j = (int'(r[7:0]) * (i + 1)) >> 8;
      t = exp_deck[i]; exp_deck[i] = exp_deck[j]; exp_deck[j] = t;
      r = lfsr_step(r);
    end
  endtask

  // Pulse start (optionally with draw held) and follow the 52-cycle shuffle.
  task automatic do_shuffle(input bit hold_draw);
    start_shuffle = 1'b1;
    draw_card     = hold_draw;
    @(negedge clk);
    start_shuffle = 1'b0;
    chk("start_ready_drop", 64'(ready), 64'd0);
    chk("start_left_clear", 64'(cards_left), 64'd0);
    @(negedge clk);
    model_shuffle(m_lfsr);
    for (int e = 2; e <= 51; e++) begin
      @(negedge clk);
      chk("busy_ready", 64'(ready), 64'd0);
      chk("busy_left", 64'(cards_left), 64'd0);
    end
    draw_card = 1'b0;
    @(negedge clk);
    chk("ready_at_52", 64'(ready), 64'd1);
    chk("left_at_52", 64'(cards_left), 64'd52);
    chk("empty_at_52", 64'(empty), 64'd0);
  endtask

  // Draw the full deck, checking order, count and that all 52 cards appear.
  task automatic draw_all();
    logic [63:0] seen;
    seen = 64'd0;
    for (int k = 0; k < 52; k++) begin
      chk("top_card", 64'(top_card), 64'(exp_deck[k]));
      chk("left_count", 64'(cards_left), 64'(52 - k));
      seen[int'(top_card[1:0]) * 13 + int'(top_card[5:2])] = 1'b1;
      draw_card = 1'b1;
      @(negedge clk);
    end
    draw_card = 1'b0;
    chk("distinct_cards", seen, 64'h000F_FFFF_FFFF_FFFF);
    chk("drained_ready", 64'(ready), 64'd0);
    chk("drained_empty", 64'(empty), 64'd1);
    chk("drained_left", 64'(cards_left), 64'd0);
    chk("drained_top", 64'(top_card), 64'(exp_deck[51]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_left", 64'(cards_left), 64'd0);
    chk("rst_top", 64'(top_card), 64'd0);

    // Idle draws do nothing.
    draw_card = 1'b1;
    @(negedge clk);
    draw_card = 1'b0;
    chk("idle_draw_left", 64'(cards_left), 64'd0);
    repeat (8) @(negedge clk);

    // Shuffle with draw held high throughout, then deal everything.
    do_shuffle(1'b1);
    draw_all();

    // Overdraw.
    draw_card = 1'b1;
    repeat (60) @(negedge clk);
    draw_card = 1'b0;
    chk("over_left", 64'(cards_left), 64'd0);
    chk("over_empty", 64'(empty), 64'd1);
    chk("over_ready", 64'(ready), 64'd0);
    chk("over_top", 64'(top_card), 64'(exp_deck[51]));

    // Restart in the middle of a shuffle.
    start_shuffle = 1'b1;
    @(negedge clk);
    start_shuffle = 1'b0;
    repeat (20) @(negedge clk);
    do_shuffle(1'b0);

    // Five draws, then start and draw together: the restart wins.
    draw_card = 1'b1;
    repeat (5) @(negedge clk);
    draw_card = 1'b0;
    chk("five_left", 64'(cards_left), 64'd47);
    chk("five_top", 64'(top_card), 64'(exp_deck[5]));
    do_shuffle(1'b1);
    draw_all();

    // Reset in the middle of a shuffle.
    start_shuffle = 1'b1;
    @(negedge clk);
    start_shuffle = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_left", 64'(cards_left), 64'd0);
    chk("midrst_top", 64'(top_card), 64'd0);
    chk("midrst_state", 64'(dut.state), 64'd0);

    // Deck still works after the reset.
    repeat (3) @(negedge clk);
    do_shuffle(1'b0);
    draw_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
